// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit mode byte transmitter: power-on nibble sequence, then
// handshake-fed bytes split into two E-strobed nibbles plus completion wait.
module lcd_nibble_writer #(
    parameter int unsigned T_POWERUP    = 750000,
    parameter int unsigned T_INIT_GAP1  = 205000,
    parameter int unsigned T_INIT_GAP2  = 5000,
    parameter int unsigned T_INIT_GAP3  = 2000,
    parameter int unsigned T_SETUP      = 2,
    parameter int unsigned T_PULSE      = 12,
    parameter int unsigned T_HOLD       = 2,
    parameter int unsigned T_NIBBLE_GAP = 50,
    parameter int unsigned T_CMD        = 2000,
    parameter int unsigned T_CLEAR      = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       rs_in,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic       init_done,
    output logic [3:0] dataout,
    output logic [2:0] control
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        SETUP,
        PULSE,
        HOLD,
        INIT_GAP,
        IDLE,
        GAP,
        POST
    } state_t;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [1:0]  idx, idx_n;
    logic        lo, lo_n;
    logic [7:0]  byte_q, byte_n;
    logic        rs_q, rs_n;
    logic [3:0]  data_n;
    logic [2:0]  ctrl_n;
    logic        ready_n, done_n;
    logic        last;
    logic        is_clear;

    function automatic logic [3:0] init_nib(input logic [1:0] i);
        return (i == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [31:0] init_gap(input logic [1:0] i);
        case (i)
            2'd0:    return T_INIT_GAP1;
            2'd1:    return T_INIT_GAP2;
            default: return T_INIT_GAP3;
        endcase
    endfunction

    assign last     = (cnt == 32'd1);
    assign is_clear = !rs_q && (byte_q >= 8'd1) && (byte_q <= 8'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PWR_WAIT;
            cnt       <= T_POWERUP;
            idx       <= 2'd0;
            lo        <= 1'b0;
            byte_q    <= 8'd0;
            rs_q      <= 1'b0;
            dataout   <= 4'd0;
            control   <= 3'd0;
            wr_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            lo        <= lo_n;
            byte_q    <= byte_n;
            rs_q      <= rs_n;
            dataout   <= data_n;
            control   <= ctrl_n;
            wr_ready  <= ready_n;
            init_done <= done_n;
        end
    end

    // Outputs are registered: each transition loads the next phase's pins.
    always_comb begin
        state_n = state;
        cnt_n   = cnt - 32'd1;
        idx_n   = idx;
        lo_n    = lo;
        byte_n  = byte_q;
        rs_n    = rs_q;
        data_n  = dataout;
        ctrl_n  = control;
        ready_n = wr_ready;
        done_n  = init_done;
        case (state)
            PWR_WAIT: begin
                if (last) begin
                    state_n = SETUP;
                    cnt_n   = T_SETUP;
                    data_n  = init_nib(idx);
                    ctrl_n  = 3'b000;
                end
            end
            SETUP: begin
                if (last) begin
                    state_n = PULSE;
                    cnt_n   = T_PULSE;
                    ctrl_n  = {1'b1, rs_q, 1'b0};
                end
            end
            PULSE: begin
                if (last) begin
                    state_n = HOLD;
                    cnt_n   = T_HOLD;
                    ctrl_n  = {1'b0, rs_q, 1'b0};
                end
            end
            HOLD: begin
                if (last) begin
                    ctrl_n = 3'b000;
                    if (!init_done) begin
                        state_n = INIT_GAP;
                        cnt_n   = init_gap(idx);
                    end else if (!lo) begin
                        state_n = GAP;
                        cnt_n   = T_NIBBLE_GAP;
                    end else begin
                        state_n = POST;
                        cnt_n   = is_clear ? T_CLEAR : T_CMD;
                    end
                end
            end
            INIT_GAP: begin
                if (last) begin
                    if (idx == 2'd3) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        ready_n = 1'b1;
                    end else begin
                        idx_n   = idx + 2'd1;
                        state_n = SETUP;
                        cnt_n   = T_SETUP;
                        data_n  = init_nib(idx + 2'd1);
                    end
                end
            end
            IDLE: begin
                cnt_n = cnt;
                if (wr_valid && wr_ready) begin
                    byte_n  = din;
                    rs_n    = rs_in;
                    lo_n    = 1'b0;
                    ready_n = 1'b0;
                    data_n  = din[7:4];
                    ctrl_n  = {1'b0, rs_in, 1'b0};
                    state_n = SETUP;
                    cnt_n   = T_SETUP;
                end
            end
            GAP: begin
                if (last) begin
                    lo_n    = 1'b1;
                    data_n  = byte_q[3:0];
                    ctrl_n  = {1'b0, rs_q, 1'b0};
                    state_n = SETUP;
                    cnt_n   = T_SETUP;
                end
            end
            POST: begin
                if (last) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                end
            end
            default: begin
                state_n = PWR_WAIT;
                cnt_n   = T_POWERUP;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Bench for lcd_nibble_writer: per-cycle pin model built from phase rules,
// plus literal checks of init length, busy lengths and strobed nibbles.
module tb_lcd_nibble_writer;

    localparam int unsigned TPU  = 100;
    localparam int unsigned G1   = 20;
    localparam int unsigned G2   = 10;
    localparam int unsigned G3   = 5;
    localparam int unsigned TS   = 2;
    localparam int unsigned TP   = 12;
    localparam int unsigned TH   = 2;
    localparam int unsigned TNG  = 50;
    localparam int unsigned TCMD = 2000;
    localparam int unsigned TCLR = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'd0;
    logic       rs_in = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       init_done;
    logic [3:0] dataout;
    logic [2:0] control;

    lcd_nibble_writer #(
        .T_POWERUP(TPU), .T_INIT_GAP1(G1), .T_INIT_GAP2(G2),
        .T_INIT_GAP3(G3), .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
        .T_NIBBLE_GAP(TNG), .T_CMD(TCMD), .T_CLEAR(TCLR)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .rs_in(rs_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .init_done(init_done),
        .dataout(dataout), .control(control)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Expected {dataout, control, wr_ready, init_done}, one entry per cycle.
    logic [8:0] q[$];
    logic [8:0] idle_rec = 9'd0;
    logic [8:0] exp_v;

    typedef struct {
        logic [3:0] nib;
        logic       rs;
        int         len;
    } pulse_t;
    pulse_t pl[$];
    bit         prev_e = 1'b0;
    logic [3:0] cur_nib = 4'd0;
    logic       cur_rs = 1'b0;
    int         cur_len = 0;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    function automatic void push_n(input int n, input logic [3:0] d,
                                   input logic [2:0] c, input logic r,
                                   input logic dn);
        repeat (n) q.push_back({d, c, r, dn});
    endfunction

    function automatic void push_nib(input logic [3:0] d, input logic rs,
                                     input logic dn);
        push_n(TS, d, {1'b0, rs, 1'b0}, 1'b0, dn);
        push_n(TP, d, {1'b1, rs, 1'b0}, 1'b0, dn);
        push_n(TH, d, {1'b0, rs, 1'b0}, 1'b0, dn);
    endfunction

    function automatic void push_init();
        int g[4] = '{G1, G2, G3, G3};
        logic [3:0] nb[4] = '{4'h3, 4'h3, 4'h3, 4'h2};
        push_n(TPU - 1, 4'h0, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_nib(nb[i], 1'b0, 1'b0);
            push_n(g[i], nb[i], 3'b000, 1'b0, 1'b0);
        end
        idle_rec = {4'h2, 3'b000, 1'b1, 1'b1};
    endfunction

    function automatic void push_byte(input logic [7:0] b, input logic rs);
        int post = (!rs && b >= 8'd1 && b <= 8'd3) ? TCLR : TCMD;
        push_nib(b[7:4], rs, 1'b1);
        push_n(TNG, b[7:4], 3'b000, 1'b0, 1'b1);
        push_nib(b[3:0], rs, 1'b1);
        push_n(post, b[3:0], 3'b000, 1'b0, 1'b1);
        idle_rec = {b[3:0], 3'b000, 1'b1, 1'b1};
    endfunction

    always @(negedge clk) begin
        if (rst) exp_v = 9'd0;
        else if (q.size() > 0) exp_v = q.pop_front();
        else exp_v = idle_rec;
        total++;
        if ({dataout, control, wr_ready, init_done} !== exp_v) begin
            bad++;
            $display("FAIL pins t=%0t got=%h want=%h", $time,
                     {dataout, control, wr_ready, init_done}, exp_v);
        end
    end

    // Strobe monitor: nibble, RS and width of every LCD_E pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_e = 1'b0;
        end else begin
            if (control[2] && !prev_e) begin
                cur_nib = dataout;
                cur_rs  = control[1];
                cur_len = 1;
            end else if (control[2]) begin
                cur_len++;
            end else if (prev_e) begin
                pulse_t p;
                p.nib = cur_nib;
                p.rs  = cur_rs;
                p.len = cur_len;
                pl.push_back(p);
            end
            prev_e = control[2];
        end
    end

    task automatic chk_pl(input string nm, input int n,
                          input logic [15:0] nibs, input logic rs);
        chk({nm, " pulses"}, pl.size(), n);
        for (int i = 0; i < n && i < pl.size(); i++) begin
            chk({nm, " nib"}, int'(pl[i].nib), int'(nibs[15-4*i -: 4]));
            chk({nm, " rs"}, int'(pl[i].rs), int'(rs));
            chk({nm, " e_len"}, pl[i].len, 12);
        end
        pl.delete();
    endtask

    task automatic do_init();
        int n = 0;
        push_init();
        do begin
            @(posedge clk);
            n++;
            #1;
            wr_valid = n[0];
            din = 8'($urandom);
            rs_in = n[1];
        end while (!init_done && n < 1000);
        wr_valid = 1'b0;
        chk("init_len", n, 204);
        chk_pl("init", 4, 16'h3332, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 30000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("idle_wait", q.size(), 0);
    endtask

    task automatic send(input logic [7:0] b, input logic rs,
                        input bit keep, input int busy, input string nm);
        int n = 0;
        wait_idle();
        din = b;
        rs_in = rs;
        wr_valid = 1'b1;
        @(posedge clk);
        #1;
        push_byte(b, rs);
        if (!keep) begin
            wr_valid = 1'b0;
            din = ~b;
            rs_in = ~rs;
        end
        @(negedge clk);
        #1;
        while (!wr_ready && n < 30000) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk({nm, " busy"}, n, busy);
        chk_pl(nm, 2, {b, 8'h00}, rs);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst dataout", int'(dataout), 0);
        chk("rst control", int'(control), 0);
        chk("rst ready", int'(wr_ready), 0);
        chk("rst done", int'(init_done), 0);
        rst = 1'b0;
        do_init();

        send(8'h28, 1'b0, 1'b0, 2082, "cmd28");
        send(8'h53, 1'b1, 1'b0, 2082, "dat53");
        send(8'h01, 1'b0, 1'b0, 20082, "clr01");
        send(8'h04, 1'b0, 1'b0, 2082, "cmd04");
        send(8'h02, 1'b1, 1'b0, 2082, "dat02");
        send(8'h41, 1'b1, 1'b1, 2082, "b2b41");
        send(8'h42, 1'b1, 1'b0, 2082, "b2b42");

        // Reset during the low-nibble strobe of a byte.
        wait_idle();
        din = 8'h4A;
        rs_in = 1'b1;
        wr_valid = 1'b1;
        @(posedge clk);
        #1;
        push_byte(8'h4A, 1'b1);
        wr_valid = 1'b0;
        repeat (69) @(posedge clk);
        #1;
        chk("mid pulse ctl", int'(control), 6);
        chk("mid pulse dat", int'(dataout), 4'hA);
        #1;
        rst = 1'b1;
        q.delete();
        pl.delete();
        #1;
        chk("async dataout", int'(dataout), 0);
        chk("async control", int'(control), 0);
        chk("async ready", int'(wr_ready), 0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        do_init();
        send(8'h0C, 1'b0, 1'b0, 2082, "cmd0C");

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
